dm_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface.
- Accepts one request at a time from the pipeline's MEM stage on a req/ack handshake. Models a configurable access latency.
- Performs byte/half/word access with sign/zero extension. Emits a stall signal that freezes IF..MEM and bubbles MEM_WB until ack.

---
 rtl/dm_responder_pkg.sv | 69 ++++++
 rtl/dm_responder_if.sv | 27 ++
 rtl/dm_responder_lane_ext.sv | 34 +++
 rtl/dm_responder.sv | 114 +++++++++++
 tb/tb_dm_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder and its load lane extender.
package dm_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [TYPE_W-1:0] {
        DT_WORD   = 3'd0,
        DT_HALF_U = 3'd1,
        DT_HALF_S = 3'd2,
        DT_BYTE_U = 3'd3,
        DT_BYTE_S = 3'd4
    } dtype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request fields latched at acceptance; later bus activity is ignored.
    typedef struct packed {
        logic              we;
        logic [TYPE_W-1:0] dtype;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wd;
        logic [WORD_W-1:0] pc;
    } dm_req_t;

    // Illegal type or an access not aligned to its own size.
    function automatic logic access_bad(input logic [TYPE_W-1:0] dtype, input logic [1:0] lane);
        logic bad;
        case (dtype)
            DT_WORD:              bad = (lane != 2'd0);
            DT_HALF_U, DT_HALF_S: bad = lane[0];
            DT_BYTE_U, DT_BYTE_S: bad = 1'b0;
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Insert low-aligned store data into the addressed lanes of the old word.
    function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_word,
                                                     input logic [WORD_W-1:0] wd,
                                                     input logic [TYPE_W-1:0] dtype,
                                                     input logic [1:0]        lane);
        logic [WORD_W-1:0] w;
        w = old_word;
        case (dtype)
            DT_WORD: w = wd;
            DT_HALF_U, DT_HALF_S: begin
                if (lane[1]) w[31:16] = wd[15:0];
                else         w[15:0]  = wd[15:0];
            end
            DT_BYTE_U, DT_BYTE_S: begin
                case (lane)
                    2'd0:    w[7:0]   = wd[7:0];
                    2'd1:    w[15:8]  = wd[7:0];
                    2'd2:    w[23:16] = wd[7:0];
                    default: w[31:24] = wd[7:0];
                endcase
            end
            default: w = old_word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory responder (slave).
// The access-type field is called dtype because "type" is a reserved word.
interface dm_responder_if;
    import dm_responder_pkg::*;

    logic              req;
    logic              we;
    logic [TYPE_W-1:0] dtype;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wd;
    logic [WORD_W-1:0] pc;
    logic              ack;
    logic [WORD_W-1:0] rdata;
    logic              stall;
    logic              err;

    modport master (
        output req, we, dtype, addr, wd, pc,
        input  ack, rdata, stall, err
    );

    modport slave (
        input  req, we, dtype, addr, wd, pc,
        output ack, rdata, stall, err
    );

endinterface

// File: rtl/dm_responder_lane_ext.sv
// Load lane select plus sign/zero extension; purely combinational so a single-cycle DM can reuse it.
module dm_lane_ext
    import dm_responder_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [TYPE_W-1:0] dtype,
    output logic [WORD_W-1:0] data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (lane)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        data_c = '0;
        case (dtype)
            DT_WORD:   data_c = word;
            DT_HALF_U: data_c = {16'd0, half_v};
            DT_HALF_S: data_c = {{16{half_v[15]}}, half_v};
            DT_BYTE_U: data_c = {24'd0, byte_v};
            DT_BYTE_S: data_c = {{24{byte_v[7]}}, byte_v};
            default:   data_c = '0;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, LAT cycles of wait, one-cycle ack.
// Optional: define DM_TRACE_EN to print committed stores and error accesses.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    dm_req_t           cap;
    logic              ack_q;
    logic              err_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] cur_word_c;
    logic [WORD_W-1:0] new_word_c;
    logic [WORD_W-1:0] load_c;
    logic              bad_c;
    logic              commit_c;
    logic              unused_bits;

    // Upper address bits wrap away; pc only feeds the optional trace.
    assign idx_c       = cap.addr[IDX_W+1:2];
    assign unused_bits = ^{cap.pc, cap.addr[WORD_W-1:IDX_W+2]};

    assign cur_word_c = mem[idx_c];
    assign bad_c      = access_bad(cap.dtype, cap.addr[1:0]);
    assign new_word_c = merge_word(cur_word_c, cap.wd, cap.dtype, cap.addr[1:0]);
    assign commit_c   = (state == ST_WAIT) && (cnt == '0);

    dm_lane_ext u_lane_ext (
        .word   (cur_word_c),
        .lane   (cap.addr[1:0]),
        .dtype  (cap.dtype),
        .data_c (load_c)
    );

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.stall = bus.req & ~ack_q;

    // Request FSM; ack/err/rdata are registered on the edge that enters RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cap     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        cap   <= '{we: bus.we, dtype: bus.dtype, addr: bus.addr,
                                   wd: bus.wd, pc: bus.pc};
                        cnt   <= CNT_W'(LAT - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state   <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= bad_c;
                        rdata_q <= (bad_c || cap.we) ? '0 : load_c;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage; a store lands on the same edge that raises ack, ahead of the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (commit_c && cap.we && !bad_c) begin
            mem[idx_c] <= new_word_c;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && commit_c) begin
            if (bad_c) begin
                $display("@%h: misaligned %h", cap.pc, cap.addr);
            end else if (cap.we) begin
                $display("@%h: *%h <= %h", cap.pc, {cap.addr[WORD_W-1:2], 2'b00}, new_word_c);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: byte-level memory model with cycle-timed ack prediction.
module tb_dm_responder;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned LAT    = 2;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dm_responder_if bus ();

    dm_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          errors    = 0;
    int          stall_cnt = 0;
    logic [31:0] pc_ctr    = 32'h0000_1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    // Reference model: little-endian byte array, ack due LAT+1 cycles after the request is seen.
    logic [7:0]  mdl [NBYTES];
    int          k      = 0;
    int          ack_at = -1;
    bit          busy   = 1'b0;
    logic        m_we;
    logic [2:0]  m_t;
    logic [31:0] m_a;
    logic [31:0] m_d;

    always @(negedge clk) begin : model
        bit              exp_ack;
        bit              exp_err;
        logic [31:0]     exp_rd;
        int unsigned     sz;
        int unsigned     base;
        longint unsigned v;
        k++;
        if (!reset) begin
            busy = 1'b0;
            for (int i = 0; i < int'(NBYTES); i++) mdl[i] = 8'h00;
            chk("reset_ack", 32'(bus.ack), 32'd0);
            chk("reset_err", 32'(bus.err), 32'd0);
            chk("reset_rdata", bus.rdata, 32'd0);
        end else begin
            exp_ack = busy && (k == ack_at);
            exp_err = 1'b0;
            exp_rd  = 32'd0;
            if (exp_ack) begin
                sz      = size_of(m_t);
                exp_err = (sz == 0) || ((m_a % sz) != 0);
                base    = m_a % NBYTES;
                if (!exp_err && m_we) begin
                    for (int i = 0; i < int'(sz); i++) mdl[base + i] = 8'(m_d >> (8 * i));
                end else if (!exp_err) begin
                    v = 0;
                    for (int i = 0; i < int'(sz); i++) v += 64'(mdl[base + i]) << (8 * i);
                    if ((m_t == 3'd2 || m_t == 3'd4) && v >= (64'd1 << (8 * sz - 1)))
                        v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
                    exp_rd = v[31:0];
                end
                busy = 1'b0;
                chk("rdata", bus.rdata, exp_rd);
            end
            chk("ack", 32'(bus.ack), 32'(exp_ack));
            chk("err", 32'(bus.err), 32'(exp_err));
            chk("stall", 32'(bus.stall), 32'(bus.req && !exp_ack));
            if (bus.stall) stall_cnt++;
            if (!busy && !exp_ack && bus.req) begin
                m_we   = bus.we;
                m_t    = bus.dtype;
                m_a    = bus.addr;
                m_d    = bus.wd;
                busy   = 1'b1;
                ack_at = k + 1 + int'(LAT);
            end
        end
    end

    // Present a request, wait for ack (bounded), return in the cycle after ack with req still high.
    task automatic access(input logic w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input bit scr, input bit drop,
                          output logic [31:0] rd, output logic e, output int n);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.dtype = t;
        bus.addr  = a;
        bus.wd    = d;
        bus.pc    = pc_ctr;
        pc_ctr   += 4;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!bus.ack) begin
                if (scr) begin
                    bus.we    = 1'($urandom);
                    bus.dtype = 3'($urandom);
                    bus.addr  = $urandom;
                    bus.wd    = $urandom;
                    bus.pc    = $urandom;
                end
                if (drop && $urandom_range(0, 1) == 1) bus.req = 1'b0;
            end
        end while (!bus.ack && n < 50);
        chk("ack_seen", 32'(bus.ack), 32'd1);
        rd = bus.rdata;
        e  = bus.err;
        @(posedge clk); #1;
    endtask

    task automatic dir(input string name, input logic w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input bit keep);
        logic [31:0] rd;
        logic        e;
        int          n;
        int          s0;
        s0 = stall_cnt;
        access(w, t, a, d, 1'b0, 1'b0, rd, e, n);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, 32'(e), 32'(exp_err));
        chk({name, "_latency"}, 32'(n), 32'(LAT + 1));
        chk({name, "_stall_cycles"}, 32'(stall_cnt - s0), 32'(LAT + 1));
        if (!keep) begin
            bus.req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.dtype = 3'd0;
        bus.addr  = 32'd0;
        bus.wd    = 32'd0;
        bus.pc    = 32'd0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("init_rdata", bus.rdata, 32'd0);
        chk("init_ack", 32'(bus.ack), 32'd0);
        chk("init_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;

        dir("st_word",   1'b1, 3'd0, 32'h10, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        dir("ld_word",   1'b0, 3'd0, 32'h10, 32'h0,         32'h1234_5678, 1'b0, 1'b0);
        dir("st_byte",   1'b1, 3'd3, 32'h13, 32'hABCD_EF80, 32'h0000_0000, 1'b0, 1'b0);
        dir("ld_byte_s", 1'b0, 3'd4, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0);
        dir("ld_byte_u", 1'b0, 3'd3, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 1'b0);
        dir("ld_word2",  1'b0, 3'd0, 32'h10, 32'h0,         32'h8034_5678, 1'b0, 1'b0);
        dir("ld_half_s", 1'b0, 3'd2, 32'h12, 32'h0,         32'hFFFF_8034, 1'b0, 1'b0);
        dir("ld_half_u", 1'b0, 3'd1, 32'h10, 32'h0,         32'h0000_5678, 1'b0, 1'b0);
        dir("ld_misal",  1'b0, 3'd0, 32'h11, 32'h0,         32'h0000_0000, 1'b1, 1'b0);
        dir("st_w20",    1'b1, 3'd0, 32'h20, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0);
        dir("st_misal",  1'b1, 3'd1, 32'h21, 32'h0000_1111, 32'h0000_0000, 1'b1, 1'b0);
        dir("ld_w20",    1'b0, 3'd0, 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0);
        dir("ld_illeg",  1'b0, 3'd5, 32'h20, 32'h0,         32'h0000_0000, 1'b1, 1'b0);
        dir("st_wrap",   1'b1, 3'd0, 32'h24 + NBYTES, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        dir("ld_wrap",   1'b0, 3'd0, 32'h24, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);

        // Back-to-back: req never drops between the two loads.
        s0 = stall_cnt;
        dir("b2b_first",  1'b0, 3'd0, 32'h10, 32'h0, 32'h8034_5678, 1'b0, 1'b1);
        dir("b2b_second", 1'b0, 3'd0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("b2b_total_stall", 32'(stall_cnt - s0 - 0), 32'd6);

        // Reset while a store to 0x40 is waiting.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.dtype = 3'd0;
        bus.addr  = 32'h40;
        bus.wd    = 32'h55AA_55AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset   = 1'b0;
        bus.req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        dir("ld_after_rst", 1'b0, 3'd0, 32'h40, 32'h0, 32'h0000_0000, 1'b0, 1'b0);

        for (int it = 0; it < 400; it++) begin
            logic [2:0]  t;
            logic [31:0] a;
            logic [31:0] rd;
            logic        e;
            int          n;
            int unsigned sz;
            t  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            sz = size_of(t);
            if (sz != 0 && $urandom_range(0, 7) != 0) a = a - (a % sz);
            access(1'($urandom), t, a, $urandom, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), rd, e, n);
            if ($urandom_range(0, 2) != 0) begin
                bus.req = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        bus.req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
